// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer driven by a one-second prescaler.
// start_level (re)loads the start value; add_bonus adds BONUS_SEC with saturation at 99.
//
// state   | meaning
// IDLE    | after reset, digits 00, waiting for start_level
// RUN     | counting down while enable_timer=1 and pause=0
// EXPIRED | reached 00, waiting for start_level
module bcd_countdown_timer #(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter logic [3:0]  START_TENS = 4'd6,
    parameter logic [3:0]  START_ONES = 4'd0,
    parameter logic [3:0]  BONUS_SEC  = 4'd5,
    parameter int unsigned LOW_THRESH = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_level,
    input  logic       enable_timer,
    input  logic       pause,
    input  logic       add_bonus,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       one_sec,
    output logic       low_time
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;
    logic          one_sec_q, one_sec_d;

    logic       is_zero, count_en, tick, do_bonus, carry;
    logic [3:0] dec_ones, dec_tens;
    logic [4:0] sum_ones, adj_ones;
    logic [4:0] sum_tens;
    logic [3:0] bon_ones, bon_tens;
    logic [7:0] value_bin;

    always_comb begin
        is_zero  = (ones_q == 4'd0) && (tens_q == 4'd0);
        count_en = (state_q == RUN) && enable_timer && !pause && !is_zero;
        tick     = count_en && (presc_q == PRESC_MAX);
        do_bonus = (state_q == RUN) && add_bonus;

        dec_ones = ones_q;
        dec_tens = tens_q;
        if (tick) begin
            if (ones_q != 4'd0) begin
                dec_ones = ones_q - 4'd1;
            end else begin
                dec_ones = 4'd9;
                dec_tens = tens_q - 4'd1;
            end
        end

        // Bonus is applied on top of any decrement happening in the same cycle.
        sum_ones = {1'b0, dec_ones} + {1'b0, BONUS_SEC};
        carry    = (sum_ones > 5'd9);
        adj_ones = carry ? (sum_ones - 5'd10) : sum_ones;
        sum_tens = {1'b0, dec_tens} + {4'd0, carry};
        if (sum_tens > 5'd9) begin
            bon_ones = 4'd9;
            bon_tens = 4'd9;
        end else begin
            bon_ones = adj_ones[3:0];
            bon_tens = sum_tens[3:0];
        end

        ones_d    = do_bonus ? bon_ones : dec_ones;
        tens_d    = do_bonus ? bon_tens : dec_tens;
        one_sec_d = tick;

        if ((state_q != RUN) || !enable_timer || is_zero) begin
            presc_d = '0;
        end else if (pause) begin
            presc_d = presc_q;
        end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        state_d = state_q;
        if ((state_q == RUN) && tick && (ones_d == 4'd0) && (tens_d == 4'd0)) begin
            state_d = EXPIRED;
        end

        if (start_level) begin
            state_d   = RUN;
            presc_d   = '0;
            ones_d    = START_ONES;
            tens_d    = START_TENS;
            one_sec_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            one_sec_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            one_sec_q <= one_sec_d;
        end
    end

    assign value_bin = (8'(tens_q) * 8'd10) + 8'(ones_q);
    assign low_time  = (state_q == RUN) && !is_zero && (32'(value_bin) <= LOW_THRESH);

    assign ones    = ones_q;
    assign tens    = tens_q;
    assign one_sec = one_sec_q;

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 50_000_000: clocks per one-second tick (min 2).
REQ-002 SHALL provide parameter START_TENS, default 4'd6: tens digit loaded at level start.
REQ-003 SHALL provide parameter START_ONES, default 4'd0: ones digit loaded at level start.
REQ-004 SHALL provide parameter BONUS_SEC, default 4'd5: seconds added per bonus pulse (0..9).
REQ-005 SHALL provide parameter LOW_THRESH, default 10: low-time warning threshold, in seconds.
REQ-006 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port start_level, input, 1: one-cycle pulse that loads the start value.
REQ-009 SHALL have port enable_timer, input, 1: level; counting permitted while high.
REQ-010 SHALL have port pause, input, 1: level; freezes counting without losing the partial second.
REQ-011 SHALL have port add_bonus, input, 1: one-cycle pulse that adds BONUS_SEC.
REQ-012 SHALL have port ones, output, 4: BCD ones digit, registered.
REQ-013 SHALL have port tens, output, 4: BCD tens digit, registered.
REQ-014 SHALL have port one_sec, output, 1: one-cycle pulse coincident with each decrement.
REQ-015 SHALL have port low_time, output, 1: high while RUN and value is at most LOW_THRESH and nonzero.

Function
REQ-016 FSM states SHALL be IDLE, RUN and EXPIRED.
REQ-017 IDLE SHALL go to RUN on start_level.
REQ-018 RUN SHALL go to EXPIRED on the decrement that produces 00.
REQ-019 EXPIRED SHALL go to RUN on start_level.
REQ-020 start_level in any state SHALL load {START_TENS, START_ONES}, clear the prescaler and enter RUN next cycle.
REQ-021 start_level SHALL have priority over tick, bonus and pause in the same cycle.
REQ-022 Prescaler SHALL count 0..TICK_DIV-1 only when state=RUN, enable_timer=1 and pause=0.
REQ-023 A tick SHALL occur on the cycle the prescaler equals TICK_DIV-1; the prescaler SHALL wrap to 0 on that cycle.
REQ-024 Digits and one_sec SHALL update on the clock edge ending the tick cycle (1-cycle latency).
REQ-025 pause=1 SHALL hold the prescaler value.
REQ-026 enable_timer=0 SHALL clear the prescaler to 0; digits SHALL hold.
REQ-027 Decrement: if ones>0, ones SHALL become ones-1; otherwise ones SHALL become 9 and tens SHALL become tens-1.
REQ-028 At 00 the value SHALL never wrap; it SHALL hold 00 and the prescaler SHALL hold 0.
REQ-029 Bonus in RUN SHALL be a BCD addition with carry from ones into tens.
REQ-030 Bonus results above 99 SHALL saturate to 99.
REQ-031 add_bonus in IDLE or EXPIRED SHALL be ignored.
REQ-032 add_bonus is not gated by pause or enable_timer.
REQ-033 Simultaneous tick and add_bonus SHALL yield value-1+BONUS_SEC, saturated at 99, with one_sec=1.
REQ-034 If value-1 equals 00 and BONUS_SEC=0 on that cycle, the block SHALL go to EXPIRED.
REQ-035 one_sec SHALL be 0 in every cycle without a decrement.
REQ-036 ones SHALL never exceed 9 and tens SHALL never exceed 9.
REQ-037 Non-BCD START values are illegal; behaviour with them is not specified.
REQ-038 low_time SHALL be combinational from state and the registered digits; it SHALL be 0 in IDLE and EXPIRED.
REQ-039 The step from 01 to 00 SHALL take exactly one cycle, so the downstream end-of-timer detector sees ones=1,tens=0 followed by ones=0,tens=0.

Reset
REQ-040 reset=1 SHALL immediately force state=IDLE, prescaler=0, ones=0, tens=0 and one_sec=0, independent of clk.
REQ-041 While reset=1, low_time SHALL be 0.
REQ-042 Mid-count reset SHALL discard the value and the partial second.
REQ-043 After reset deassertion the block SHALL stay in IDLE until start_level.

Verification (TICK_DIV=4, START=60, BONUS_SEC=5, LOW_THRESH=10)
REQ-044 Bench SHALL cover: start_level, enable_timer=1 -> 60 next cycle; 59 after 4 more cycles with one_sec pulsing once; 58 four cycles later.
REQ-045 Bench SHALL cover: value 10, run to end -> sequence 09..01 then 00; state EXPIRED; digits hold 00 for 20 further cycles; no further one_sec.
REQ-046 Bench SHALL cover: value 97, add_bonus -> 99 (saturated); value 37 with add_bonus on a tick cycle -> 41 with one_sec=1.
REQ-047 Bench SHALL cover: pause for 10 cycles after the prescaler reaches 2 -> digits frozen, tick 2 cycles after release; enable_timer low for 1 cycle -> next tick 4 cycles after re-enable.
REQ-048 Bench SHALL cover: reset pulsed between clock edges at value 25 -> outputs 00 immediately, state IDLE; ticks and add_bonus ignored until start_level.
REQ-049 Bench SHALL cover: start_level with add_bonus and tick in the same cycle at value 12 -> 60, one_sec=0; low_time=1 at values 10..01 only.
